cipher_point_buffer: RTL
========================

CIPHER_POINT_BUFFER -- requirements
Module: cipher_point_buffer

Interface
REQ-001 Parameter DEPTH, default 4, is the number of records stored; it SHALL be a power of two, 2..16.
REQ-002 Parameter GAP, default 2, is the number of idle cycles after each replay; it SHALL be 1..7.
REQ-003 clk  in  1  clock; all logic is on the rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 pt_strobe  in  1  single-cycle strobe; a cipher point record is present on the point inputs.
REQ-006 x1_in, y1_in, x2_in, y2_in  in  8 each  cipher point pair (point 1, point 2).
REQ-007 replay_en  in  1  level signal that permits replay toward the decrypt path.
REQ-008 valid_out  out  1  one-cycle marker for the first point of a replayed record.
REQ-009 x_out, y_out  out  8 each  replayed point coordinates.
REQ-010 full, empty  out  1 each  buffer status.
REQ-011 level  out  $clog2(DEPTH)+1  number of stored records.
REQ-012 overflow  out  1  sticky flag; a strobe arrived while the buffer was full.

Function
REQ-013 A record is {x1,y1,x2,y2} (32 bits); the block SHALL push a record on every cycle where pt_strobe=1 and full=0.
REQ-014 On a strobe with full=1, the block SHALL discard the record, leave the buffer unchanged and set overflow.
REQ-015 Write and read pointers SHALL wrap modulo DEPTH; level SHALL equal writes minus reads, and full=(level==DEPTH), empty=(level==0).
REQ-016 The replay FSM SHALL have the states IDLE, SEND_A, SEND_B and WAIT.
REQ-017 IDLE->SEND_A when replay_en=1 and empty=0 (evaluated in the current cycle); the record is popped on this transition.
REQ-018 SEND_A, one cycle: valid_out=1, x_out=x1, y_out=y1.
REQ-019 SEND_B, one cycle: valid_out=0, x_out=x2, y_out=y2.
REQ-020 WAIT, GAP cycles: valid_out=0, and x_out/y_out hold the point 2 values; after GAP cycles the FSM SHALL return to IDLE.
REQ-021 In IDLE, valid_out=0 and x_out/y_out SHALL hold their last values.
REQ-022 Deasserting replay_en SHALL NOT abort a record already in SEND_A, SEND_B or WAIT; the record SHALL complete.
REQ-023 All outputs SHALL be registered; the first valid_out SHALL occur 1 cycle after the IDLE cycle in which the start condition holds.
REQ-024 A push and a pop in the same cycle SHALL both take effect; level SHALL stay unchanged and full SHALL not block that push.
REQ-025 A strobe into an empty buffer with replay_en=1 SHALL give valid_out 2 cycles after the strobe cycle (no bypass path).
REQ-026 Back-to-back records SHALL be spaced exactly 2+GAP cycles apart, valid_out to valid_out.

Reset
REQ-027 Under reset the block SHALL set: FSM=IDLE, pointers=0, level=0, empty=1, full=0, overflow=0, valid_out=0, x_out=0, y_out=0.
REQ-028 A reset in mid-replay SHALL abandon the current record with no further valid_out; buffer contents are discarded.
REQ-029 The only way to clear overflow SHALL be reset.

Structure
REQ-030 A shared package SHALL hold the record type (4x8-bit struct), the FSM state enum and the DEPTH/GAP defaults.
REQ-031 The storage SHALL be one sub-module, point_fifo: a register-array FIFO with push/pop/full/empty/level.
REQ-032 The FSM and the output registers SHALL reside in cipher_point_buffer.

Verification
REQ-033 Reset, then one strobe {0x11,0x22,0x33,0x44} with replay_en=1 -> valid_out=1 with x=0x11/y=0x22 at strobe+2; the next cycle gives x=0x33/y=0x44 with valid_out=0; then 2 idle cycles.
REQ-034 With replay_en=0, 5 strobes at DEPTH=4 -> full=1 after the 4th, overflow=1 after the 5th, level=4; enabling replay returns records 1-4 in order.
REQ-035 Level 4, with a strobe in the same cycle as the pop (IDLE->SEND_A) -> level stays 4 and the new record is accepted.
REQ-036 Continuous replay of 3 records -> valid_out pulses exactly 4 cycles apart (GAP=2).
REQ-037 replay_en is dropped during SEND_B -> the record completes, and no further valid_out occurs while replay_en=0.
REQ-038 Reset is asserted during WAIT with 2 records stored -> valid_out=0, empty=1, level=0, x_out/y_out=0 on the next cycle.

Source files
------------

// File: rtl/cipher_point_buffer_pkg.sv
// Shared types for the cipher point replay buffer.
//   point_rec_t : one cipher point pair {x1,y1,x2,y2}, 8 bits per coordinate
//   rpl_state_t : replay FSM states
//   DEF_DEPTH / DEF_GAP : default record count and post-replay idle cycles
package cipher_point_buffer_pkg;

  localparam int DEF_DEPTH = 4;
  localparam int DEF_GAP   = 2;

  typedef struct packed {
    logic [7:0] x1;
    logic [7:0] y1;
    logic [7:0] x2;
    logic [7:0] y2;
  } point_rec_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND_A,
    ST_SEND_B,
    ST_WAIT
  } rpl_state_t;

endpackage

// File: rtl/cipher_point_buffer_point_fifo.sv
// point_fifo: register-array FIFO of point records.
//   clk, reset : clock, synchronous active-high reset
//   i_push     : write i_wdata (accepted if not full, or if popping this cycle)
//   i_pop      : drop head record (ignored when empty)
//   o_rdata    : head record (combinational read of the head slot)
//   o_full, o_empty, o_level : registered status
module point_fifo
  import cipher_point_buffer_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_push,
  input  logic          i_pop,
  input  point_rec_t    i_wdata,
  output point_rec_t    o_rdata,
  output logic          o_full,
  output logic          o_empty,
  output logic [LW-1:0] o_level
);

  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  point_rec_t    r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [LW-1:0] r_level;
  logic          r_full, r_empty;

  logic          w_push, w_pop;
  logic [LW-1:0] w_level_nxt;

  // A simultaneous pop frees a slot, so a full buffer still takes the push.
  assign w_push = i_push && (!r_full || i_pop);
  assign w_pop  = i_pop && !r_empty;

  always_comb begin
    w_level_nxt = r_level;
    if (w_push && !w_pop)      w_level_nxt = r_level + 1'b1;
    else if (!w_push && w_pop) w_level_nxt = r_level - 1'b1;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      r_level <= w_level_nxt;
      r_full  <= (w_level_nxt == FULL_LVL);
      r_empty <= (w_level_nxt == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_wdata;
  end

  assign o_rdata = r_mem[r_rptr];
  assign o_full  = r_full;
  assign o_empty = r_empty;
  assign o_level = r_level;

endmodule

// File: rtl/cipher_point_buffer.sv
// cipher_point_buffer: stores cipher point records and replays them toward
// the decrypt path as point 1 (marked by valid_out) then point 2, followed by
// GAP quiet cycles.
//   clk, reset          : clock, synchronous active-high reset
//   pt_strobe           : record {x1,y1,x2,y2}_in present this cycle
//   replay_en           : level enable for starting a replay
//   valid_out           : marks the point-1 cycle of a replayed record
//   x_out, y_out        : replayed coordinates (registered, held when idle)
//   full, empty, level  : buffer status
//   overflow            : sticky, a strobe was dropped because buffer was full
module cipher_point_buffer
  import cipher_point_buffer_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int GAP   = DEF_GAP,
  localparam int LW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          pt_strobe,
  input  logic [7:0]    x1_in,
  input  logic [7:0]    y1_in,
  input  logic [7:0]    x2_in,
  input  logic [7:0]    y2_in,
  input  logic          replay_en,
  output logic          valid_out,
  output logic [7:0]    x_out,
  output logic [7:0]    y_out,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level,
  output logic          overflow
);

  localparam logic [2:0] GAP_LAST = 3'(GAP - 1);

  rpl_state_t r_state, w_state_nxt;
  logic [2:0] r_cnt, w_cnt_nxt;
  logic [7:0] r_x2, r_y2, w_x2_nxt, w_y2_nxt;
  logic [7:0] r_x, r_y, w_x_nxt, w_y_nxt;
  logic       r_vld, w_vld_nxt;
  logic       r_ovf;

  point_rec_t w_wrec, w_rrec;
  logic       w_full, w_empty, w_pop, w_start, w_decide;

  assign w_wrec = '{x1: x1_in, y1: y1_in, x2: x2_in, y2: y2_in};

  point_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (pt_strobe),
    .i_pop   (w_pop),
    .i_wdata (w_wrec),
    .o_rdata (w_rrec),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (level)
  );

  assign w_start = replay_en && !w_empty;
  // The last WAIT cycle doubles as the IDLE decision cycle, so consecutive
  // records land exactly 2+GAP cycles apart.
  assign w_decide = (r_state == ST_IDLE) ||
                    (r_state == ST_WAIT && r_cnt == GAP_LAST);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_x2_nxt    = r_x2;
    w_y2_nxt    = r_y2;
    w_x_nxt     = r_x;
    w_y_nxt     = r_y;
    w_vld_nxt   = 1'b0;
    w_pop       = 1'b0;
    if (w_decide) begin
      if (w_start) begin
        w_state_nxt = ST_SEND_A;
        w_pop       = 1'b1;
        w_vld_nxt   = 1'b1;
        w_x_nxt     = w_rrec.x1;
        w_y_nxt     = w_rrec.y1;
        w_x2_nxt    = w_rrec.x2;
        w_y2_nxt    = w_rrec.y2;
      end else begin
        w_state_nxt = ST_IDLE;
      end
    end else begin
      unique case (r_state)
        ST_SEND_A: begin
          w_state_nxt = ST_SEND_B;
          w_x_nxt     = r_x2;
          w_y_nxt     = r_y2;
        end
        ST_SEND_B: begin
          w_state_nxt = ST_WAIT;
          w_cnt_nxt   = '0;
        end
        ST_WAIT:  w_cnt_nxt = r_cnt + 1'b1;
        default:  w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_x2    <= '0;
      r_y2    <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_vld   <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_x2    <= w_x2_nxt;
      r_y2    <= w_y2_nxt;
      r_x     <= w_x_nxt;
      r_y     <= w_y_nxt;
      r_vld   <= w_vld_nxt;
      // A strobe that coincides with a pop is accepted, not dropped.
      if (pt_strobe && w_full && !w_pop) r_ovf <= 1'b1;
    end
  end

  assign valid_out = r_vld;
  assign x_out     = r_x;
  assign y_out     = r_y;
  assign full      = w_full;
  assign empty     = w_empty;
  assign overflow  = r_ovf;

endmodule
